// File: rtl/soc_system_hps_data_fifo.sv
// Avalon-MM slave that pushes words into a show-ahead FIFO drained through a valid/ready stream.
// The overflow interrupt (irq port, CONTROL[1]) exists only when HPS_DATA_FIFO_IRQ_EN is defined.
module soc_system_hps_data_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef HPS_DATA_FIFO_IRQ_EN
    ,
    output logic              irq
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Stream handshake: a word transfers on every rising edge where out_valid and out_ready are both 1.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [31:0]       shadow_q, shadow_d;
    logic              irq_en_q, irq_en_d;
    logic              wr, push, pop, full, accept, flush, ovf_set, ovf_clr;
    logic [LW-1:0]     level_vis;
    logic              unused_wdata;

    assign unused_wdata = ^writedata;

    always_comb begin
        // Outputs read as empty while reset is held, regardless of the registered state.
        level_vis = reset ? '0 : level_q;
        out_valid = (level_vis != '0);
        out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

        wr      = chipselect & ~write_n;
        push    = wr & (address == 2'd0);
        full    = (level_q == LW'(DEPTH));
        pop     = out_valid & out_ready;
        accept  = push & (~full | pop);
        flush   = wr & (address == 2'd2) & writedata[0];
        ovf_set = push & full & ~pop;
        ovf_clr = wr & (address == 2'd1) & writedata[2];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        shadow_d = shadow_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            shadow_d = 32'(writedata[DATA_W-1:0]);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (accept && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !accept) begin
            level_d = level_q - LW'(1);
        end
        // Flush wins over a concurrent pop: the consumer sees the transfer, the state just restarts.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
        overflow_d = ovf_set | (overflow_q & ~ovf_clr);
`ifdef HPS_DATA_FIFO_IRQ_EN
        irq_en_d = (wr && address == 2'd2) ? writedata[1] : irq_en_q;
`else
        irq_en_d = 1'b0;
`endif

        case (address)
            2'd0:    readdata = shadow_q;
            2'd1:    readdata = {16'h0, 8'(level_vis), 5'h0, overflow_q & ~reset,
                                 (level_vis == LW'(DEPTH)), (level_vis == '0)};
            2'd2:    readdata = {30'h0, irq_en_q, 1'b0};
            default: readdata = {8'h0, 8'(DATA_W), 16'(DEPTH)};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            shadow_q   <= '0;
            irq_en_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            shadow_q   <= shadow_d;
            irq_en_q   <= irq_en_d;
        end
    end

    // Storage is never reset; only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            mem_q[wr_ptr_q] <= writedata[DATA_W-1:0];
        end
    end

`ifdef HPS_DATA_FIFO_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = overflow_q & irq_en_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: doc/soc_system_hps_data_fifo.md
SOC_SYSTEM_HPS_DATA_FIFO -- requirements
Module: soc_system_hps_data_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, output word width; legal range 1..32.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; power of 2, range 2..128.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port address  in  2  Avalon-MM slave word address.
REQ-006 SHALL have port chipselect  in  1  slave select.
REQ-007 SHALL have port write_n  in  1  active-low write strobe.
REQ-008 SHALL have port writedata  in  32  write data.
REQ-009 SHALL have port readdata  out  32  combinational read data, zero wait states, unused bits 0.
REQ-010 SHALL have port out_data  out  DATA_W  head-of-FIFO word.
REQ-011 SHALL have port out_valid  out  1  out_data holds a valid word.
REQ-012 SHALL have port out_ready  in  1  consumer accepts the word.
REQ-013 SHALL have port irq  out  1  overflow interrupt (present only per REQ-030).

Function
REQ-014 SHALL define wr = chipselect & ~write_n; push = wr & address==0; pop = out_valid & out_ready.
REQ-015 SHALL store writedata[DATA_W-1:0] on push when not full, or when full and pop in the same cycle (level unchanged).
REQ-016 SHALL drop a push when full and no pop; SHALL set sticky overflow.
REQ-017 SHALL be show-ahead: a word pushed into an empty FIFO in cycle N is on out_data with out_valid=1 from cycle N+1.
REQ-018 SHALL drive out_data=0 and out_valid=0 when empty.
REQ-019 SHALL preserve FIFO order; pointers wrap modulo DEPTH; level range 0..DEPTH, width clog2(DEPTH)+1.
REQ-020 SHALL update a shadow register with every accepted pushed word (zero-extended); dropped words do not update it.
REQ-021 SHALL map reads: addr0 = shadow; addr1 = STATUS {level at [15:8], overflow [2], full [1], empty [0]}; addr2 = CONTROL {irq_en [1]}; addr3 = {DATA_W at [23:16], DEPTH at [15:0]}.
REQ-022 SHALL flush on a write to addr2 with writedata[0]=1: level, pointers to 0 next cycle; a simultaneous pop completes for the consumer but the word is discarded; flush bit reads 0.
REQ-023 SHALL clear overflow on a write to addr1 with writedata[2]=1; a same-cycle overflow set wins over the clear.
REQ-024 SHALL ignore writes to addr3 and to undefined bits.

Reset
REQ-025 SHALL, with reset high at a clock edge, set level 0, pointers 0, overflow 0, shadow 0, irq_en 0.
REQ-026 SHALL hold out_valid=0, out_data=0, readdata STATUS = 0x00000001 during and after reset.
REQ-027 SHALL discard in-flight push/pop/flush in a reset cycle; reset has priority over all other events.
REQ-028 SHALL not require FIFO storage contents to be reset.

Configuration
REQ-029 SHALL compile the interrupt feature only when macro HPS_DATA_FIFO_IRQ_EN is defined.
REQ-030 With HPS_DATA_FIFO_IRQ_EN: irq port exists, registered, irq = overflow & irq_en, asserts the cycle after both hold; CONTROL[1] is read/write.
REQ-031 Without HPS_DATA_FIFO_IRQ_EN: no irq port; CONTROL[1] reads 0, writes ignored.

Verification
REQ-032 Reset, then read addr1 -> 0x00000001; out_valid=0; addr3 -> 0x00200008 (defaults).
REQ-033 out_ready=0, push 0xA1,0xA2,0xA3 -> out_valid=1 cycle after first push, out_data=0xA1; addr1 level=3; addr0=0xA3; with out_ready=1, pops in order A1,A2,A3, then empty.
REQ-034 out_ready=0, push 9 words 0x1..0x9 at DEPTH=8 -> full=1, overflow=1, addr0=0x8, 0x9 never output; write addr1 0x4 -> overflow=0.
REQ-035 Full FIFO, push 0x55 with out_ready=1 same cycle -> accepted, level stays 8, no overflow, 0x55 emerges last.
REQ-036 Level 5, write addr2 0x1 with out_ready=1 -> next cycle level=0, out_valid=0, empty=1; reset asserted mid-stream -> identical state to REQ-032.
REQ-037 With HPS_DATA_FIFO_IRQ_EN: irq_en=1, overflow -> irq=1 next cycle; clear overflow -> irq=0; with irq_en=0 irq stays 0.
